// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_unit
// Description : Register-file write-back arbiter merging MEM/WB results with a
//               buffered mul/div result stream; mirrors commits for forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback_unit #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIPE_VALID,
  input  logic [4:0]  PIPE_RD,
  input  logic [1:0]  PIPE_WBSEL,
  input  logic [2:0]  PIPE_FUNCT3,
  input  logic [31:0] PIPE_ALU,
  input  logic [31:0] PIPE_MEM,
  input  logic [31:0] PIPE_PC4,
  input  logic        MD_VALID,
  input  logic [4:0]  MD_RD,
  input  logic [31:0] MD_DATA,
  output logic        MD_READY,
  output logic        STALL_PIPE,
  output logic        WRITE,
  output logic [4:0]  INADDRESS,
  output logic [31:0] IN,
  output logic        FWD_VALID,
  output logic [4:0]  FWD_RD,
  output logic [31:0] FWD_DATA
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] c_WB_ALU = 2'b00;
  localparam logic [1:0] c_WB_MEM = 2'b01;
  localparam logic [1:0] c_WB_PC4 = 2'b10;
  localparam logic [1:0] c_WB_NONE = 2'b11;

  logic [4:0]         r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]        r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_STV_W-1:0] r_starve;
  logic               r_stall;
  logic               r_write;
  logic [4:0]         r_addr;
  logic [31:0]        r_data;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_pipe_req;
  logic               w_grant_pipe;
  logic [31:0]        w_load;
  logic [31:0]        w_pipe_data;
  logic [c_STV_W-1:0] w_starve_nxt;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign MD_READY     = !w_full && !RESET;
  assign w_push       = MD_VALID && MD_READY && (MD_RD != 5'd0);
  assign w_pipe_req   = PIPE_VALID && (PIPE_WBSEL != c_WB_NONE) && (PIPE_RD != 5'd0);
  // A stall slot belongs to the FIFO head regardless of what the pipeline offers.
  assign w_grant_pipe = !r_stall && w_pipe_req;
  assign w_pop        = !w_empty && (r_stall || !w_pipe_req);
  assign w_starve_nxt = (w_empty || w_pop) ? '0 : r_starve + 1'b1;

  always_comb begin
    w_load = PIPE_MEM;
    case (PIPE_FUNCT3)
      3'b000:  w_load = {{24{PIPE_MEM[7]}}, PIPE_MEM[7:0]};
      3'b001:  w_load = {{16{PIPE_MEM[15]}}, PIPE_MEM[15:0]};
      3'b100:  w_load = {24'd0, PIPE_MEM[7:0]};
      3'b101:  w_load = {16'd0, PIPE_MEM[15:0]};
      default: w_load = PIPE_MEM;
    endcase
  end

  always_comb begin
    w_pipe_data = PIPE_ALU;
    case (PIPE_WBSEL)
      c_WB_ALU: w_pipe_data = PIPE_ALU;
      c_WB_MEM: w_pipe_data = w_load;
      c_WB_PC4: w_pipe_data = PIPE_PC4;
      default:  w_pipe_data = PIPE_ALU;
    endcase
  end

  // Storage needs no reset: occupancy is tracked solely by r_count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= MD_RD;
      r_fifo_data[r_wptr] <= MD_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == c_STV_W'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_write <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
    end else if (w_grant_pipe) begin
      r_write <= 1'b1;
      r_addr  <= PIPE_RD;
      r_data  <= w_pipe_data;
    end else if (w_pop) begin
      r_write <= 1'b1;
      r_addr  <= r_fifo_rd[r_rptr];
      r_data  <= r_fifo_data[r_rptr];
    end else begin
      r_write <= 1'b0;
    end
  end

  assign STALL_PIPE = r_stall;
  assign WRITE      = r_write;
  assign INADDRESS  = r_addr;
  assign IN         = r_data;
  assign FWD_VALID  = r_write;
  assign FWD_RD     = r_addr;
  assign FWD_DATA   = r_data;

endmodule
`default_nettype wire
